// File: rtl/riscv_pkg.sv
// Shared core types: ALU operation encoding used by the datapath.
package riscv_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_ops_t;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit integer ALU. Comparison flags are always computed
// from the operands, independent of the selected operation; unknown
// operations produce a zero result.
module alu (
  input  logic                [31:0] a,
  input  logic                [31:0] b,
  input  riscv_pkg::alu_ops_t        op,
  output logic                [31:0] result,
  output logic                       zero,
  output logic                       is_less,
  output logic                       is_less_u
);

  logic less_s;
  logic less_u_s;

  // Operation select and flag generation.
  always_comb begin
    less_s   = ($signed(a) < $signed(b));
    less_u_s = (a < b);
    case (op)
      riscv_pkg::ALU_ADD:  result = a + b;
      riscv_pkg::ALU_SUB:  result = a - b;
      riscv_pkg::ALU_AND:  result = a & b;
      riscv_pkg::ALU_OR:   result = a | b;
      riscv_pkg::ALU_XOR:  result = a ^ b;
      riscv_pkg::ALU_SLL:  result = a << b[4:0];
      riscv_pkg::ALU_SRL:  result = a >> b[4:0];
      riscv_pkg::ALU_SRA:  result = $unsigned($signed(a) >>> b[4:0]);
      riscv_pkg::ALU_SLT:  result = {31'd0, less_s};
      riscv_pkg::ALU_SLTU: result = {31'd0, less_u_s};
      default:             result = 32'd0;
    endcase
    zero      = (result == 32'd0);
    is_less   = less_s;
    is_less_u = less_u_s;
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between the execute stage (port 0) and the address/branch
// target unit (port 1). A single-entry response buffer holds the registered
// ALU outputs; a new request is only accepted when the buffer is empty or is
// being drained on the same edge, so back-to-back operation has no bubble.
module alu_share_arbiter #(
  parameter logic RR_EN = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                [1:0]  req_valid,
  output logic                [1:0]  req_ready,
  input  logic                [31:0] req_a0,
  input  logic                [31:0] req_b0,
  input  logic                [31:0] req_a1,
  input  logic                [31:0] req_b1,
  input  riscv_pkg::alu_ops_t        req_op0,
  input  riscv_pkg::alu_ops_t        req_op1,
  output logic                [1:0]  rsp_valid,
  input  logic                [1:0]  rsp_ready,
  output logic                [31:0] rsp_result,
  output logic                       rsp_zero,
  output logic                       rsp_less,
  output logic                       rsp_less_u
);

  // Buffer state encoding doubles as the one-hot response owner.
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_FULL0 = 2'b01;
  localparam logic [1:0] ST_FULL1 = 2'b10;

  logic [1:0]          state_r;
  logic                last_grant_r;
  logic [31:0]         result_r;
  logic                zero_r;
  logic                less_r;
  logic                less_u_r;

  logic                drain_s;
  logic                free_s;
  logic [1:0]          grant_s;
  logic [31:0]         alu_a_s;
  logic [31:0]         alu_b_s;
  riscv_pkg::alu_ops_t alu_op_s;
  logic [31:0]         alu_result_s;
  logic                alu_zero_s;
  logic                alu_less_s;
  logic                alu_less_u_s;

  // Buffer drain/free detection; only the owner's rsp_ready matters.
  always_comb begin
    case (state_r)
      ST_FULL0: drain_s = rsp_ready[0];
      ST_FULL1: drain_s = rsp_ready[1];
      default:  drain_s = 1'b0;
    endcase
    free_s = (state_r == ST_EMPTY) || drain_s;
  end

  // Grant selection: round-robin favours the port not served last.
  always_comb begin
    case (req_valid)
      2'b01:   grant_s = 2'b01;
      2'b10:   grant_s = 2'b10;
      2'b11: begin
        if (RR_EN) begin
          grant_s = last_grant_r ? 2'b01 : 2'b10;
        end else begin
          grant_s = 2'b01;
        end
      end
      default: grant_s = 2'b00;
    endcase
    if (free_s) begin
      req_ready = grant_s;
    end else begin
      req_ready = 2'b00;
    end
  end

  // Operand steering towards the shared ALU; port 0 is the idle default.
  always_comb begin
    if (req_ready[1]) begin
      alu_a_s  = req_a1;
      alu_b_s  = req_b1;
      alu_op_s = req_op1;
    end else begin
      alu_a_s  = req_a0;
      alu_b_s  = req_b0;
      alu_op_s = req_op0;
    end
  end

  alu u_alu (
    .a         (alu_a_s),
    .b         (alu_b_s),
    .op        (alu_op_s),
    .result    (alu_result_s),
    .zero      (alu_zero_s),
    .is_less   (alu_less_s),
    .is_less_u (alu_less_u_s)
  );

  // Response buffer: capture on grant, empty on bare drain, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_EMPTY;
      last_grant_r <= 1'b1;
      result_r     <= 32'd0;
      zero_r       <= 1'b0;
      less_r       <= 1'b0;
      less_u_r     <= 1'b0;
    end else if (req_ready != 2'b00) begin
      state_r      <= req_ready;
      last_grant_r <= req_ready[1];
      result_r     <= alu_result_s;
      zero_r       <= alu_zero_s;
      less_r       <= alu_less_s;
      less_u_r     <= alu_less_u_s;
    end else if (drain_s) begin
      state_r      <= ST_EMPTY;
    end else begin
      state_r      <= state_r;
    end
  end

  assign rsp_valid  = state_r;
  assign rsp_result = result_r;
  assign rsp_zero   = zero_r;
  assign rsp_less   = less_r;
  assign rsp_less_u = less_u_r;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: one round-robin instance and one
// fixed-priority instance share the same stimulus.
module tb_alu_share_arbiter;
  import riscv_pkg::*;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [31:0] req_a0, req_b0, req_a1, req_b1;
  alu_ops_t    req_op0, req_op1;
  logic [1:0]  rsp_ready;

  logic [1:0]  rr_req_ready, rr_rsp_valid;
  logic [31:0] rr_rsp_result;
  logic        rr_rsp_zero, rr_rsp_less, rr_rsp_less_u;

  logic [1:0]  fp_req_ready, fp_rsp_valid;
  logic [31:0] fp_rsp_result;
  logic        fp_rsp_zero, fp_rsp_less, fp_rsp_less_u;

  int checks_cnt;
  int fail_cnt;

  alu_share_arbiter #(.RR_EN(1'b1)) u_rr (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rr_req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .req_op0(req_op0), .req_op1(req_op1), .rsp_valid(rr_rsp_valid),
    .rsp_ready(rsp_ready), .rsp_result(rr_rsp_result), .rsp_zero(rr_rsp_zero),
    .rsp_less(rr_rsp_less), .rsp_less_u(rr_rsp_less_u)
  );

  alu_share_arbiter #(.RR_EN(1'b0)) u_fp (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(fp_req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .req_op0(req_op0), .req_op1(req_op1), .rsp_valid(fp_rsp_valid),
    .rsp_ready(rsp_ready), .rsp_result(fp_rsp_result), .rsp_zero(fp_rsp_zero),
    .rsp_less(fp_rsp_less), .rsp_less_u(fp_rsp_less_u)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Requester obligation on the round-robin instance: stalled requests hold their payload.
  logic        stall0_q, stall1_q;
  logic [31:0] a0_q, b0_q, a1_q, b1_q;
  alu_ops_t    op0_q, op1_q;
  always @(posedge clk) begin
    if (!rst && stall0_q && req_valid[0]) begin
      assert (req_a0 == a0_q && req_b0 == b0_q && req_op0 == op0_q)
        else $error("port 0 payload changed while stalled");
    end
    if (!rst && stall1_q && req_valid[1]) begin
      assert (req_a1 == a1_q && req_b1 == b1_q && req_op1 == op1_q)
        else $error("port 1 payload changed while stalled");
    end
    stall0_q <= req_valid[0] && !rr_req_ready[0];
    stall1_q <= req_valid[1] && !rr_req_ready[1];
    a0_q <= req_a0; b0_q <= req_b0; op0_q <= req_op0;
    a1_q <= req_a1; b1_q <= req_b1; op1_q <= req_op1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] exp_g;
    checks_cnt = 0;
    fail_cnt   = 0;
    rst        = 1'b1;
    req_valid  = 2'b11;
    rsp_ready  = 2'b00;
    req_a0 = 32'd0; req_b0 = 32'd0; req_op0 = ALU_ADD;
    req_a1 = 32'd0; req_b1 = 32'd0; req_op1 = ALU_ADD;

    // Reset held for two cycles with both ports valid.
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_rsp_valid", {30'd0, rr_rsp_valid}, 32'd0);
      check("rst_rsp_result", rr_rsp_result, 32'd0);
    end
    rst = 1'b0;
    #1;
    check("post_rst_req_ready", {30'd0, rr_req_ready}, 32'd1);

    // Single port 0: ADD 5 + 7.
    req_valid = 2'b01; req_a0 = 32'd5; req_b0 = 32'd7; req_op0 = ALU_ADD;
    rsp_ready = 2'b01;
    #1;
    check("add_req_ready", {30'd0, rr_req_ready}, 32'd1);
    tick();
    check("add_rsp_valid", {30'd0, rr_rsp_valid}, 32'd1);
    check("add_result", rr_rsp_result, 32'd12);
    check("add_zero", {31'd0, rr_rsp_zero}, 32'd0);

    // Single port 1: SUB 3 - 3, accepted while port 0 drains.
    req_valid = 2'b10; req_a1 = 32'd3; req_b1 = 32'd3; req_op1 = ALU_SUB;
    #1;
    check("sub_req_ready", {30'd0, rr_req_ready}, 32'd2);
    tick();
    check("sub_rsp_valid", {30'd0, rr_rsp_valid}, 32'd2);
    check("sub_result", rr_rsp_result, 32'd0);
    check("sub_zero", {31'd0, rr_rsp_zero}, 32'd1);

    // Idle drain by port 1 leaves the buffer empty.
    req_valid = 2'b00; rsp_ready = 2'b10;
    tick();
    check("idle_rsp_valid", {30'd0, rr_rsp_valid}, 32'd0);

    // Round-robin contention: SLT on port 0, SLTU on port 1.
    req_valid = 2'b11; rsp_ready = 2'b11;
    req_a0 = 32'hFFFF_FFFF; req_b0 = 32'd1; req_op0 = ALU_SLT;
    req_a1 = 32'hFFFF_FFFF; req_b1 = 32'd1; req_op1 = ALU_SLTU;
    for (int i = 0; i < 4; i++) begin
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      check("rr_req_ready", {30'd0, rr_req_ready}, {30'd0, exp_g});
      tick();
      check("rr_rsp_valid", {30'd0, rr_rsp_valid}, {30'd0, exp_g});
      if (exp_g == 2'b01) begin
        check("rr_slt_result", rr_rsp_result, 32'd1);
        check("rr_slt_less", {31'd0, rr_rsp_less}, 32'd1);
      end else begin
        check("rr_sltu_result", rr_rsp_result, 32'd0);
        check("rr_sltu_less_u", {31'd0, rr_rsp_less_u}, 32'd0);
      end
    end

    // Fixed priority: port 0 wins every cycle, port 1 never transfers.
    for (int i = 0; i < 4; i++) begin
      #1;
      check("fp_req_ready", {30'd0, fp_req_ready}, 32'd1);
      tick();
      check("fp_rsp_valid", {30'd0, fp_rsp_valid}, 32'd1);
    end

    // Empty the round-robin buffer (last grant was port 1).
    req_valid = 2'b00; rsp_ready = 2'b11;
    tick();
    check("bp_pre_empty", {30'd0, rr_rsp_valid}, 32'd0);

    // Backpressure: port 0 XOR wins contention, then the owner stalls.
    req_valid = 2'b11; rsp_ready = 2'b00;
    req_a0 = 32'hF0F0_F0F0; req_b0 = 32'hFFFF_0000; req_op0 = ALU_XOR;
    req_a1 = 32'd1; req_b1 = 32'd2; req_op1 = ALU_ADD;
    #1;
    check("bp_grant0", {30'd0, rr_req_ready}, 32'd1);
    tick();
    req_valid = 2'b10;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_req_ready", {30'd0, rr_req_ready}, 32'd0);
      check("bp_rsp_valid", {30'd0, rr_rsp_valid}, 32'd1);
      check("bp_result", rr_rsp_result, 32'h0F0F_F0F0);
      tick();
    end
    rsp_ready = 2'b01;
    #1;
    check("bp_drain_grant1", {30'd0, rr_req_ready}, 32'd2);
    tick();
    check("bp_rsp_valid1", {30'd0, rr_rsp_valid}, 32'd2);
    check("bp_result1", rr_rsp_result, 32'd3);

    // Non-owner rsp_ready has no effect.
    req_valid = 2'b00; rsp_ready = 2'b01;
    tick();
    check("nonowner_rsp_valid", {30'd0, rr_rsp_valid}, 32'd2);
    check("nonowner_result", rr_rsp_result, 32'd3);

    // Reset while FULL(1) and stalled.
    rsp_ready = 2'b00; req_valid = 2'b11; rst = 1'b1;
    tick();
    check("mid_rst_rsp_valid", {30'd0, rr_rsp_valid}, 32'd0);
    check("mid_rst_result", rr_rsp_result, 32'd0);
    rst = 1'b0; rsp_ready = 2'b01;
    #1;
    check("mid_rst_grant0", {30'd0, rr_req_ready}, 32'd1);
    tick();
    check("mid_rst_rsp_valid0", {30'd0, rr_rsp_valid}, 32'd1);
    check("mid_rst_result0", rr_rsp_result, 32'h0F0F_F0F0);

    // Unknown operation yields result 0 with zero flag set.
    req_valid = 2'b01; req_a0 = 32'd5; req_b0 = 32'd7; req_op0 = alu_ops_t'(4'hF);
    tick();
    check("unk_rsp_valid", {30'd0, rr_rsp_valid}, 32'd1);
    check("unk_result", rr_rsp_result, 32'd0);
    check("unk_zero", {31'd0, rr_rsp_zero}, 32'd1);

    req_valid = 2'b00;
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule
